maxq_reward_seq: RTL and testbench
==================================

Name: maxq_reward_seq

Overview:
Parametrised, sequential successor to the combinational max-Q/reward finder in the Q-learning maze datapath. On a start pulse it scans the N_ACTIONS Q entries of one maze state through a 1-cycle-latency Q-table read port and finds the greedy action and its Q value. It then computes the reward for that state/action pair. Results feed the Q-update stage through a start/busy/done handshake.

Parameters:
N_STATES, 37, number of Q-table rows; valid states are 0..N_STATES-1
N_ACTIONS, 4, actions per state; must be at least 2
Q_W, 32, Q-value width
Q_SIGNED, 0, 1 selects two's-complement compare; 0 selects unsigned compare
STATE_W, 6, state index width
ACT_W, 3, action index width
REWARD_W, 4, reward width
GOAL_REWARD, 10, reward for a goal transition
GOAL_STATE_A, 35, first goal-transition state
GOAL_ACT_A, 1, first goal-transition action
GOAL_STATE_B, 30, second goal-transition state
GOAL_ACT_B, 0, second goal-transition action

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  request a scan; sampled only in IDLE
maze_state  in  STATE_W  state to scan; latched when start is accepted
q_rd_state  out  STATE_W  Q-table read row; registered
q_rd_action  out  ACT_W  Q-table read column; registered
q_rd_data  in  Q_W  Q-table read data; valid 1 cycle after the address
busy  out  1  high while not IDLE
done  out  1  1-cycle pulse when results update
max_Q  out  Q_W  greatest Q value of the latched state
action  out  ACT_W  index of max_Q
reward  out  REWARD_W  reward for (latched state, action)
state_err  out  1  last request had maze_state >= N_STATES
valid  out  1  high once any result has been produced; cleared only by rst

Behaviour:
- Reset (synchronous, rst high at a clk edge):
  - FSM goes to IDLE.
  - All outputs go to 0, including q_rd_*, max_Q, action, reward, done, busy, valid and state_err.
- FSM states: IDLE, SCAN.
- IDLE, start high, maze_state < N_STATES:
  - Latch the state.
  - Next cycle: q_rd_state = the latched state, q_rd_action = 0, FSM = SCAN, busy = 1.
- IDLE, start high, maze_state >= N_STATES:
  - No reads are issued.
  - Next cycle: done = 1, state_err = 1, max_Q = 0, action = 0, reward = 0, valid = 1.
  - FSM stays in IDLE.
- SCAN:
  - q_rd_action increments by 1 each cycle until it reaches N_ACTIONS-1, then holds.
  - The data returned for action k is compared in the cycle after that address is presented.
  - The running maximum is initialised from the action-0 data.
  - A later action replaces the running maximum only if its value is strictly greater. Ties therefore resolve to the lowest index.
- Completion:
  - The edge that samples the action N_ACTIONS-1 data registers max_Q, action and reward.
  - At that edge: done = 1, valid = 1, state_err = 0, FSM returns to IDLE.
  - Latency: done is high exactly N_ACTIONS+2 cycles after the start edge; 6 cycles at default.
- Reward:
  - reward = GOAL_REWARD when (state, action) equals (GOAL_STATE_A, GOAL_ACT_A) or (GOAL_STATE_B, GOAL_ACT_B); otherwise 0.
  - reward is evaluated on the final winning action, never on an intermediate one.
- Holding and handshake:
  - max_Q, action, reward and state_err hold until the next done.
  - start while busy is ignored and is not queued.
  - start in the same cycle as done is accepted, since the FSM is already in IDLE; the next done follows N_ACTIONS+2 cycles later.
  - Changes to maze_state after acceptance have no effect on the scan in progress.
- Compare rules:
  - Q_SIGNED = 1: signed compare, so 32'hFFFF_FFFF (-1) is less than 0.
  - Q_SIGNED = 0: unsigned compare.
  - All Q values equal gives action = 0.
- rst mid-SCAN: abort, no done pulse, outputs cleared as for reset.
- q_rd_* return to 0 on entering IDLE.

Test Plan:
- Scan ordering: state 5, Q = {3, 9, 7, 1} -> done 6 cycles after start; max_Q = 9, action = 1, reward = 0; q_rd_action sequence 0,1,2,3.
- Goal rewards: state 35, Q = {0, 50, 2, 2} -> action = 1, reward = 10. State 30, Q = {8, 1, 1, 1} -> action = 0, reward = 10. State 35, Q = {50, 0, 0, 0} -> reward = 0.
- Ties and signed compare: Q = {4, 6, 6, 6} -> action = 1. Q = {4, 4, 4, 4} -> action = 0. Q_SIGNED = 1, Q = {FFFFFFFF, 0, FFFFFFFE, FFFFFFFD} -> action = 1, max_Q = 0.
- Handshake: start held high for 10 cycles -> exactly one done by cycle 6, and a second start accepted in the done cycle gives done again 6 cycles later; start pulsed during busy -> ignored.
- Out-of-range state: maze_state = 40 -> done and state_err at cycle +1, outputs 0, no q_rd activity.
- Reset mid-scan: rst at cycle 3 of a scan -> no done; all outputs 0; the next start completes normally.
- Generalised configuration: N_ACTIONS = 8, ACT_W = 3, max at index 7 -> action = 7, done at cycle 10.

Source files
------------

// File: rtl/maxq_reward_seq.sv
// maxq_reward_seq: sequential greedy-action finder with goal reward over a 1-cycle-latency Q-table read port
module maxq_reward_seq #(
    parameter int N_STATES     = 37,
    parameter int N_ACTIONS    = 4,
    parameter int Q_W          = 32,
    parameter int Q_SIGNED     = 0,
    parameter int STATE_W      = 6,
    parameter int ACT_W        = 3,
    parameter int REWARD_W     = 4,
    parameter int GOAL_REWARD  = 10,
    parameter int GOAL_STATE_A = 35,
    parameter int GOAL_ACT_A   = 1,
    parameter int GOAL_STATE_B = 30,
    parameter int GOAL_ACT_B   = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [STATE_W-1:0]  maze_state,
    output logic [STATE_W-1:0]  q_rd_state,
    output logic [ACT_W-1:0]    q_rd_action,
    input  logic [Q_W-1:0]      q_rd_data,
    output logic                busy,
    output logic                done,
    output logic [Q_W-1:0]      max_Q,
    output logic [ACT_W-1:0]    action,
    output logic [REWARD_W-1:0] reward,
    output logic                state_err,
    output logic                valid
);
    typedef enum logic {IDLE, SCAN} fsm_t;
    fsm_t fsm;
    logic [STATE_W-1:0] lat_state;
    logic [ACT_W:0] cnt;
    logic [Q_W-1:0] run_max, win_q;
    logic [ACT_W-1:0] run_act, win_act;
    logic gt, take, last, goal;
    // cnt counts SCAN edges; data for action k arrives when cnt == k+1
    always_comb begin
        gt = Q_SIGNED != 0 ? $signed(q_rd_data) > $signed(run_max) : q_rd_data > run_max;
        take = cnt == (ACT_W+1)'(1) || gt;
        win_act = take ? ACT_W'(cnt - 1'b1) : run_act;
        win_q = take ? q_rd_data : run_max;
        last = cnt == (ACT_W+1)'(N_ACTIONS);
        goal = (lat_state == STATE_W'(GOAL_STATE_A) && win_act == ACT_W'(GOAL_ACT_A)) ||
               (lat_state == STATE_W'(GOAL_STATE_B) && win_act == ACT_W'(GOAL_ACT_B));
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm <= IDLE;
            lat_state <= '0;
            cnt <= '0;
            run_max <= '0;
            run_act <= '0;
            q_rd_state <= '0;
            q_rd_action <= '0;
            busy <= 1'b0;
            done <= 1'b0;
            max_Q <= '0;
            action <= '0;
            reward <= '0;
            state_err <= 1'b0;
            valid <= 1'b0;
        end else begin
            done <= 1'b0;
            if (fsm == IDLE) begin
                if (start && 32'(maze_state) < N_STATES) begin
                    lat_state <= maze_state;
                    q_rd_state <= maze_state;
                    q_rd_action <= '0;
                    cnt <= '0;
                    busy <= 1'b1;
                    fsm <= SCAN;
                end else if (start) begin
                    done <= 1'b1;
                    state_err <= 1'b1;
                    max_Q <= '0;
                    action <= '0;
                    reward <= '0;
                    valid <= 1'b1;
                end
            end else begin
                cnt <= cnt + 1'b1;
                if (q_rd_action != ACT_W'(N_ACTIONS-1))
                    q_rd_action <= q_rd_action + 1'b1;
                if (cnt != '0) begin
                    run_max <= win_q;
                    run_act <= win_act;
                end
                if (last) begin
                    max_Q <= win_q;
                    action <= win_act;
                    reward <= goal ? REWARD_W'(GOAL_REWARD) : '0;
                    done <= 1'b1;
                    valid <= 1'b1;
                    state_err <= 1'b0;
                    busy <= 1'b0;
                    q_rd_state <= '0;
                    q_rd_action <= '0;
                    fsm <= IDLE;
                end
            end
        end
    end
endmodule

// File: tb/tb_maxq_reward_seq.sv
// tb_maxq_reward_seq: scoreboard bench for a default 4-action unsigned unit and an 8-action signed unit
module tb_maxq_reward_seq;
    typedef logic [31:0] qv_t [8];
    typedef struct {
        logic [31:0] q;
        logic [2:0]  a;
        logic [3:0]  r;
        logic        e;
        int          cyc;
    } exp_t;

    logic clk = 0, rst = 1;
    logic start0 = 0, start1 = 0;
    logic [5:0] ms0 = 0, ms1 = 0;
    logic [5:0] qs0, qs1;
    logic [2:0] qa0, qa1, act0, act1;
    logic [31:0] rd0, rd1, mq0, mq1;
    logic [3:0] rw0, rw1;
    logic busy0, busy1, done0, done1, err0, err1, val0, val1;
    qv_t qv0 = '{default: 0}, qv1 = '{default: 0};
    exp_t sb0[$], sb1[$];
    logic [2:0] trace0[$];
    int cyc = 0, checks = 0, errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) begin
        rd0 <= qv0[qa0];
        rd1 <= qv1[qa1];
    end

    maxq_reward_seq u0 (
        .clk(clk), .rst(rst), .start(start0), .maze_state(ms0),
        .q_rd_state(qs0), .q_rd_action(qa0), .q_rd_data(rd0),
        .busy(busy0), .done(done0), .max_Q(mq0), .action(act0),
        .reward(rw0), .state_err(err0), .valid(val0));

    maxq_reward_seq #(.N_ACTIONS(8), .Q_SIGNED(1)) u1 (
        .clk(clk), .rst(rst), .start(start1), .maze_state(ms1),
        .q_rd_state(qs1), .q_rd_action(qa1), .q_rd_data(rd1),
        .busy(busy1), .done(done1), .max_Q(mq1), .action(act1),
        .reward(rw1), .state_err(err1), .valid(val1));

    task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", n, got, exp);
        end
    endtask

    task automatic cmp(input string p, input exp_t e, input logic [31:0] q, input logic [2:0] a,
                       input logic [3:0] r, input logic er, input logic v);
        chk({p, " max_Q"}, q, e.q);
        chk({p, " action"}, 32'(a), 32'(e.a));
        chk({p, " reward"}, 32'(r), 32'(e.r));
        chk({p, " state_err"}, 32'(er), 32'(e.e));
        chk({p, " valid"}, 32'(v), 1);
        chk({p, " done_cycle"}, cyc, e.cyc);
    endtask

    always @(negedge clk) begin
        if (busy0) trace0.push_back(qa0);
        if (!rst && done0) begin
            if (sb0.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL d0 unexpected_done: got done at cycle %0d expected none", cyc);
            end else cmp("d0", sb0.pop_front(), mq0, act0, rw0, err0, val0);
        end
        if (!rst && done1) begin
            if (sb1.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL d1 unexpected_done: got done at cycle %0d expected none", cyc);
            end else cmp("d1", sb1.pop_front(), mq1, act1, rw1, err1, val1);
        end
    end

    task automatic issue(input int d, input logic [5:0] s, input qv_t q, input logic [31:0] em,
                         input logic [2:0] ea, input logic [3:0] er, input logic ee);
        @(negedge clk);
        if (d == 0) begin
            qv0 = q; ms0 = s; start0 = 1;
            sb0.push_back('{em, ea, er, ee, cyc + (ee ? 1 : 6)});
        end else begin
            qv1 = q; ms1 = s; start1 = 1;
            sb1.push_back('{em, ea, er, ee, cyc + (ee ? 1 : 10)});
        end
        @(negedge clk);
        start0 = 0; start1 = 0;
        repeat (ee ? 2 : 11) @(negedge clk);
    endtask

    initial begin
        logic [2:0] exp_tr [5] = '{0, 1, 2, 3, 3};
        int c;
        repeat (3) @(negedge clk);
        rst = 0;
        @(negedge clk);
        chk("reset outputs", {mq0[15:0], 3'(act0), rw0, err0, val0, busy0, done0, 2'(qa0)}, 0);
        chk("reset q_rd_state", 32'(qs0), 0);
        chk("reset d1 outputs", {mq1[15:0], 3'(act1), rw1, err1, val1, busy1, done1, 2'(qa1)}, 0);

        trace0.delete();
        issue(0, 5, '{3, 9, 7, 1, 0, 0, 0, 0}, 9, 1, 0, 0);
        chk("trace_len", trace0.size(), 5);
        for (int i = 0; i < 5 && i < trace0.size(); i++) chk($sformatf("trace[%0d]", i), 32'(trace0[i]), 32'(exp_tr[i]));
        issue(0, 35, '{0, 50, 2, 2, 0, 0, 0, 0}, 50, 1, 10, 0);
        issue(0, 30, '{8, 1, 1, 1, 0, 0, 0, 0}, 8, 0, 10, 0);
        issue(0, 35, '{50, 0, 0, 0, 0, 0, 0, 0}, 50, 0, 0, 0);
        issue(0, 7, '{4, 6, 6, 6, 0, 0, 0, 0}, 6, 1, 0, 0);
        issue(0, 7, '{4, 4, 4, 4, 0, 0, 0, 0}, 4, 0, 0, 0);
        issue(0, 9, '{32'hFFFF_FFFF, 0, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 0, 0, 0, 0}, 32'hFFFF_FFFF, 0, 0, 0);
        issue(0, 36, '{1, 2, 3, 4, 0, 0, 0, 0}, 4, 3, 0, 0);

        trace0.delete();
        issue(0, 40, '{1, 2, 3, 4, 0, 0, 0, 0}, 0, 0, 0, 1);
        chk("oor no reads", trace0.size(), 0);
        chk("oor q_rd", {26'(qs0), 3'(qa0)}, 0);
        issue(0, 37, '{1, 2, 3, 4, 0, 0, 0, 0}, 0, 0, 0, 1);

        issue(1, 30, '{32'hFFFF_FFFF, 0, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 0, 32'hFFFF_FFF0}, 0, 1, 0, 0);
        issue(1, 35, '{1, 2, 3, 4, 5, 6, 7, 100}, 100, 7, 0, 0);
        issue(1, 30, '{5, 1, 2, 3, 4, 32'hFFFF_FFFF, 0, 5}, 5, 0, 10, 0);

        // start held high: accepted at once and again in the done cycle
        @(negedge clk);
        qv0 = '{3, 9, 7, 1, 0, 0, 0, 0}; ms0 = 5; start0 = 1; c = cyc;
        sb0.push_back('{9, 1, 0, 0, c + 6});
        sb0.push_back('{9, 1, 0, 0, c + 12});
        repeat (10) @(negedge clk);
        start0 = 0;
        repeat (8) @(negedge clk);

        // start pulse and state change while busy must be ignored
        c = cyc;
        start0 = 1; sb0.push_back('{9, 1, 0, 0, c + 6});
        @(negedge clk); start0 = 0;
        @(negedge clk); start0 = 1; ms0 = 35;
        @(negedge clk); start0 = 0;
        repeat (10) @(negedge clk);

        // reset mid-scan
        qv0 = '{2, 3, 1, 0, 0, 0, 0, 0}; ms0 = 35; start0 = 1;
        @(negedge clk); start0 = 0;
        @(negedge clk);
        @(negedge clk); rst = 1;
        @(negedge clk); rst = 0;
        chk("midrst outputs", {mq0[15:0], 3'(act0), rw0, err0, val0, busy0, done0, 2'(qa0)}, 0);
        chk("midrst q_rd_state", 32'(qs0), 0);
        repeat (8) @(negedge clk);
        chk("midrst valid held 0", 32'(val0), 0);
        issue(0, 35, '{2, 3, 1, 0, 0, 0, 0, 0}, 3, 1, 10, 0);

        repeat (5) @(negedge clk);
        chk("sb0 drained", sb0.size(), 0);
        chk("sb1 drained", sb1.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end
endmodule
